// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational RV32I ALU between NUM_REQ requesters. A
//   round-robin arbiter picks one valid requester per cycle, drives its
//   operands/op onto the ALU, and captures the ALU result into a one-entry
//   response register tagged with the requester id.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-requester handshake; at most one ready bit high
//   req_a, req_b        packed operands, requester i at [i*XLEN +: XLEN]
//   req_sub_arith       per-requester sub / arithmetic-shift select
//   req_op              packed ALU ops, requester i at [i*OP_W +: OP_W]
//   alu_a/b/sub_arith/op  drive to the shared ALU (zero when nothing granted)
//   alu_res             combinational ALU result
//   rsp_valid/ready     response handshake
//   rsp_id, rsp_res     requester index and registered result
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int OP_W    = 3,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub_arith,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic                    alu_sub_arith,
  output logic [OP_W-1:0]         alu_op,
  input  logic [XLEN-1:0]         alu_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_res
);

  localparam int unsigned N = NUM_REQ;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               can_accept;
  logic               grant_any;

  assign can_accept = !rsp_valid || rsp_ready;

  // Scan from ptr, wrapping; the index is kept ID_W wide so it never
  // leaves 0..NUM_REQ-1 even for non-power-of-two NUM_REQ.
  always_comb begin
    int unsigned sum;
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = ID_W'(sum);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    // rst gating keeps req_ready low while reset is held, where
    // can_accept would otherwise be true from the cleared response.
    if (found && can_accept && rst) grant[grant_idx] = 1'b1;
  end

  assign grant_any = |grant;
  assign req_ready = grant;

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_sub_arith = 1'b0;
    alu_op        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        alu_a         = req_a[i*XLEN +: XLEN];
        alu_b         = req_b[i*XLEN +: XLEN];
        alu_sub_arith = req_sub_arith[i];
        alu_op        = req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      ptr       <= '0;
    end else if (grant_any) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_idx;
      rsp_res   <= alu_res;
      if (32'(grant_idx) == N - 1) ptr <= '0;
      else                         ptr <= grant_idx + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
